// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with fill count, almost-full/almost-empty thresholds,
// overflow/underflow error pulses and selectable first-word-fall-through read.
// Status flags are registered and are recomputed from the next pointer state,
// so they always agree with the registered count and never glitch.
module sync_fifo_thresh #(
   parameter int DATA_WIDTH    = 8,
   parameter int DATA_DEPTH    = 16,
   parameter int PTR_WIDTH     = 4,
   parameter int AFULL_THRESH  = 12,
   parameter int AEMPTY_THRESH = 4,
   parameter int FWFT          = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  w_en,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  r_en,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [PTR_WIDTH:0]    count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [PTR_WIDTH:0] DEPTH_LVL  = (PTR_WIDTH+1)'(DATA_DEPTH);
   localparam logic [PTR_WIDTH:0] AFULL_LVL  = (PTR_WIDTH+1)'(AFULL_THRESH);
   localparam logic [PTR_WIDTH:0] AEMPTY_LVL = (PTR_WIDTH+1)'(AEMPTY_THRESH);
   localparam logic [PTR_WIDTH:0] PTR_ONE    = (PTR_WIDTH+1)'(1);

   // Storage is deliberately not reset; empty gating hides stale words.
   logic [DATA_WIDTH-1:0] mem [0:DATA_DEPTH-1];

   logic [PTR_WIDTH:0]    w_ptr;
   logic [PTR_WIDTH:0]    r_ptr;
   logic [PTR_WIDTH:0]    w_ptr_next;
   logic [PTR_WIDTH:0]    r_ptr_next;
   logic [PTR_WIDTH:0]    count_next;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [DATA_WIDTH-1:0] r_data_reg;
   logic [DATA_WIDTH-1:0] fwft_data;

   // Acceptance from pre-edge flags, next pointers, and the resulting fill level.
   always_comb begin
      wr_acc     = 1'b0;
      rd_acc     = 1'b0;
      w_ptr_next = w_ptr;
      r_ptr_next = r_ptr;
      count_next = count;

      wr_acc = w_en && !full;
      rd_acc = r_en && !empty;

      if (wr_acc) begin
         w_ptr_next = w_ptr + PTR_ONE;
      end else begin
         w_ptr_next = w_ptr;
      end

      if (rd_acc) begin
         r_ptr_next = r_ptr + PTR_ONE;
      end else begin
         r_ptr_next = r_ptr;
      end

      // Binary pointers with one extra wrap bit: their difference is the fill level.
      count_next = w_ptr_next - r_ptr_next;
   end

   // Pointers, count, registered status flags and error pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_ptr        <= '0;
         r_ptr        <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         w_ptr        <= w_ptr_next;
         r_ptr        <= r_ptr_next;
         count        <= count_next;
         full         <= (count_next == DEPTH_LVL);
         empty        <= (count_next == '0);
         almost_full  <= (count_next >= AFULL_LVL);
         almost_empty <= (count_next <= AEMPTY_LVL);
         overflow     <= w_en && full;
         underflow    <= r_en && empty;
      end
   end

   // Memory write port; nothing lands during a reset cycle.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem[w_ptr[PTR_WIDTH-1:0]] <= w_data;
      end
   end

   // Standard-mode read register: loads on an accepted read, holds otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data_reg <= '0;
      end else if (rd_acc) begin
         r_data_reg <= mem[r_ptr[PTR_WIDTH-1:0]];
      end else begin
         r_data_reg <= r_data_reg;
      end
   end

   // Fall-through view of the head word, forced to zero while empty.
   always_comb begin
      fwft_data = '0;
      if (empty) begin
         fwft_data = '0;
      end else begin
         fwft_data = mem[r_ptr[PTR_WIDTH-1:0]];
      end
   end

   assign r_data = (FWFT != 0) ? fwft_data : r_data_reg;

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Scoreboard bench for sync_fifo_thresh: one standard-mode and one FWFT instance
// share the same directed stimulus; monitors compare read data against queues.
module tb_sync_fifo_thresh;

   logic       clk;
   logic       rst;
   logic       w_en;
   logic [7:0] w_data;
   logic       r_en;

   logic [7:0] s_rdata, f_rdata;
   logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
   logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
   logic [4:0] s_count, f_count;

   int checks   = 0;
   int failures = 0;

   // Bench-side expectation controls, set by the driver alongside the stimulus.
   logic wr_expect;
   logic rd_expect;
   logic std_pend;
   logic mon_on;

   logic [7:0] exp_q[$];   // hand-computed standard-mode read results
   logic [7:0] fw_q[$];    // words the FWFT instance should be showing

   sync_fifo_thresh #(.FWFT(0)) dut_std (
      .clk(clk), .rst(rst), .w_en(w_en), .w_data(w_data), .r_en(r_en),
      .r_data(s_rdata), .full(s_full), .empty(s_empty),
      .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
      .overflow(s_ovf), .underflow(s_udf)
   );

   sync_fifo_thresh #(.FWFT(1)) dut_fw (
      .clk(clk), .rst(rst), .w_en(w_en), .w_data(w_data), .r_en(r_en),
      .r_data(f_rdata), .full(f_full), .empty(f_empty),
      .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
      .overflow(f_ovf), .underflow(f_udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard bookkeeping at the clock edge (inputs are stable here).
   always @(posedge clk) begin
      if (rst) begin
         fw_q.delete();
         std_pend <= 1'b0;
      end else begin
         std_pend <= rd_expect;
         if (rd_expect && fw_q.size() > 0) void'(fw_q.pop_front());
         if (wr_expect) fw_q.push_back(w_data);
      end
   end

   // Monitor: compare read data on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (mon_on) begin
         if (std_pend) begin
            if (exp_q.size() == 0) begin
               chk("std_rdata_unexpected", 32'd1, 32'd0);
            end else begin
               chk("std_rdata", {24'd0, s_rdata}, {24'd0, exp_q.pop_front()});
            end
         end
         if (fw_q.size() > 0) begin
            chk("fw_rdata", {24'd0, f_rdata}, {24'd0, fw_q[0]});
         end else begin
            chk("fw_rdata_empty", {24'd0, f_rdata}, 32'd0);
         end
      end
   end

   // One clock of stimulus; rval is the hand-computed word a standard read returns.
   task automatic step(input logic r, input logic w, input logic [7:0] d, input logic rd,
                       input logic wexp, input logic rexp, input logic [7:0] rval);
      rst       = r;
      w_en      = w;
      w_data    = d;
      r_en      = rd;
      wr_expect = wexp;
      rd_expect = rexp;
      if (rexp) exp_q.push_back(rval);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      w_en      = 1'b0;
      r_en      = 1'b0;
      wr_expect = 1'b0;
      rd_expect = 1'b0;
   endtask

   task automatic chk_state(input string tag, input int cnt, input logic fu, input logic em,
                            input logic af, input logic ae, input logic ov, input logic un);
      chk({tag, "_std_count"}, {27'd0, s_count}, cnt);
      chk({tag, "_std_full"},  {31'd0, s_full},  {31'd0, fu});
      chk({tag, "_std_empty"}, {31'd0, s_empty}, {31'd0, em});
      chk({tag, "_std_afull"}, {31'd0, s_af},    {31'd0, af});
      chk({tag, "_std_aempty"},{31'd0, s_ae},    {31'd0, ae});
      chk({tag, "_std_ovf"},   {31'd0, s_ovf},   {31'd0, ov});
      chk({tag, "_std_udf"},   {31'd0, s_udf},   {31'd0, un});
      chk({tag, "_fw_count"},  {27'd0, f_count}, cnt);
      chk({tag, "_fw_empty"},  {31'd0, f_empty}, {31'd0, em});
      chk({tag, "_fw_full"},   {31'd0, f_full},  {31'd0, fu});
      chk({tag, "_fw_ovf"},    {31'd0, f_ovf},   {31'd0, ov});
      chk({tag, "_fw_udf"},    {31'd0, f_udf},   {31'd0, un});
   endtask

   initial begin
      rst = 1'b1; w_en = 1'b0; r_en = 1'b0; w_data = 8'h00;
      wr_expect = 1'b0; rd_expect = 1'b0; mon_on = 1'b0;

      // Reset with requests active: they must be ignored.
      step(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 8'h00);
      mon_on = 1'b1;
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      chk_state("reset", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("reset_std_rdata", {24'd0, s_rdata}, 32'd0);

      // Fill with 0x01..0x10.
      for (int i = 1; i <= 16; i++) begin
         step(1'b0, 1'b1, 8'(i), 1'b0, 1'b1, 1'b0, 8'h00);
         chk_state("fill", i, (i == 16), 1'b0, (i >= 12), (i <= 4), 1'b0, 1'b0);
      end

      // Full with both requests: read 0x01 accepted, 0xAA dropped.
      step(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 8'h01);
      chk_state("ovf", 15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      chk_state("ovf_clear", 15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Drain 0x02..0x10 in order.
      for (int i = 2; i <= 16; i++) begin
         step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'(i));
      end
      chk_state("drained", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      // Empty with both requests: write 0x5C accepted, read rejected.
      step(1'b0, 1'b1, 8'h5C, 1'b1, 1'b1, 1'b0, 8'h00);
      chk_state("udf", 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("udf_std_rdata_hold", {24'd0, s_rdata}, 32'h10);
      chk("udf_fw_rdata", {24'd0, f_rdata}, 32'h5C);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      chk_state("udf_clear", 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5C);

      // FWFT fall-through sequence.
      step(1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("fwft_first", {24'd0, f_rdata}, 32'h11);
      step(1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00);
      chk("fwft_hold_head", {24'd0, f_rdata}, 32'h11);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11);
      chk("fwft_pop1", {24'd0, f_rdata}, 32'h22);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22);
      chk("fwft_pop2", {24'd0, f_rdata}, 32'h00);
      chk("fwft_empty", {31'd0, f_empty}, 32'd1);

      // Wrap-around at fill level 3.
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 8'(8'h30 + i), 1'b0, 1'b1, 1'b0, 8'h00);
      end
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 1'b1, 8'(8'h33 + i), 1'b1, 1'b1, 1'b1, 8'(8'h30 + i));
         chk({24'd0, 3'd0, s_count} == 32'd3 ? "wrap_count" : "wrap_count", {27'd0, s_count}, 32'd3);
      end

      // Reset mid-stream with requests active.
      step(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 8'h00);
      chk_state("midrst", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("midrst_std_rdata", {24'd0, s_rdata}, 32'd0);

      // Only post-reset data comes out.
      step(1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 8'h78, 1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h77);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h78);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
      chk_state("final", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
